// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, LFSR seed and
// taps, apple playfield limits, reset apple location and saturation limits.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] X_LIMIT   = 8'd160;
  localparam logic [8:0] Y_LIMIT   = 9'd120;
  localparam logic [7:0] RESET_X   = 8'd15;
  localparam logic [8:0] RESET_Y   = 9'd12;
  localparam logic [7:0] MAX_SIZE  = 8'd255;
  localparam logic [2:0] MAX_LEVEL = 3'd7;

  // Fold a raw 8-bit random value into the 0..159 column range.
  function automatic logic [7:0] wrap_x(input logic [7:0] raw);
    return (raw >= X_LIMIT) ? (raw - X_LIMIT) : raw;
  endfunction

  // Fold a raw 7-bit random value into the 0..119 row range.
  function automatic logic [8:0] wrap_y(input logic [6:0] raw);
    logic [8:0] y;
    y = {2'b00, raw};
    return (y >= Y_LIMIT) ? (y - Y_LIMIT) : y;
  endfunction

endpackage

// File: rtl/score_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the apple location source.
// It steps on every clock regardless of game state; reset loads a non-zero
// seed so the all-zero lock-up state is never reached.
module score_lfsr
  import score_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic feedback;

  // XOR of the tapped bits shifted in at the bottom.
  always_comb begin
    feedback = ^(value & LFSR_TAPS);
  end

  // Shift register with synchronous reload of the seed.
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Snake game score keeper: IDLE/PLAY/OVER FSM tracking snake size, level and
// apple location, plus a screen tick divider.
// Optional build macro SCORE_KEEPER_DEBUG_EN adds a debugMode input that makes
// the snake invincible (collision ignored in PLAY) while high.
//
// Input pulses (start, appleEaten, collision) carry no handshake: every cycle
// a pulse is sampled high counts as one event, so a level held for N cycles is
// N events. Outputs are all registered and valid every cycle.
module score_keeper
  import score_pkg::*;
#(
  parameter int CLOCK_HZ   = 50000000,
  parameter int TICK_HZ    = 4,
  parameter int LEVEL_STEP = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       appleEaten,
  input  logic       collision,
`ifdef SCORE_KEEPER_DEBUG_EN
  input  logic       debugMode,
`endif
  output logic       screenClock,
  output logic [7:0] size,
  output logic [2:0] level,
  output logic       gameOver,
  output logic [7:0] appleLocX,
  output logic [8:0] appleLocY
);

  localparam int DIV_MAX = CLOCK_HZ / (2 * TICK_HZ) - 1;
  localparam int DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_MAX);
  localparam logic [7:0]       STEP_LAST = 8'(LEVEL_STEP - 1);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       apple_cnt, apple_cnt_n;
  logic [7:0]       size_n;
  logic [2:0]       level_n;
  logic             game_over_n;
  logic [7:0]       loc_x_n;
  logic [8:0]       loc_y_n;
  logic [15:0]      lfsr;
  logic             lfsr_unused;
  logic             coll_eff;

  // Top LFSR bit is not part of either coordinate.
  assign lfsr_unused = lfsr[15];

  score_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr)
  );

  // Effective collision: masked by invincible mode when that feature is built.
  always_comb begin
`ifdef SCORE_KEEPER_DEBUG_EN
    coll_eff = collision & ~debugMode;
`else
    coll_eff = collision;
`endif
  end

  // Screen tick divider: toggles on the terminal count, runs in all states.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt     <= '0;
      screenClock <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt     <= '0;
      screenClock <= ~screenClock;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next values of all game registers.
  always_comb begin
    state_n     = state;
    size_n      = size;
    level_n     = level;
    game_over_n = gameOver;
    apple_cnt_n = apple_cnt;
    loc_x_n     = appleLocX;
    loc_y_n     = appleLocY;
    case (state)
      ST_IDLE: begin
        size_n      = 8'd1;
        level_n     = 3'd0;
        game_over_n = 1'b0;
        apple_cnt_n = 8'd0;
        if (start) begin
          state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Collision wins over a simultaneous apple and freezes the score.
        if (coll_eff) begin
          state_n     = ST_OVER;
          game_over_n = 1'b1;
        end else if (appleEaten) begin
          size_n = (size == MAX_SIZE) ? size : size + 8'd1;
          if (apple_cnt == STEP_LAST) begin
            apple_cnt_n = 8'd0;
            level_n     = (level == MAX_LEVEL) ? level : level + 3'd1;
          end else begin
            apple_cnt_n = apple_cnt + 8'd1;
          end
          loc_x_n = wrap_x(lfsr[7:0]);
          loc_y_n = wrap_y(lfsr[14:8]);
        end
      end
      ST_OVER: begin
        if (start) begin
          state_n     = ST_PLAY;
          size_n      = 8'd1;
          level_n     = 3'd0;
          apple_cnt_n = 8'd0;
          game_over_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Game registers, all outputs driven straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      size      <= 8'd1;
      level     <= 3'd0;
      gameOver  <= 1'b0;
      apple_cnt <= 8'd0;
      appleLocX <= RESET_X;
      appleLocY <= RESET_Y;
    end else begin
      size      <= size_n;
      level     <= level_n;
      gameOver  <= game_over_n;
      apple_cnt <= apple_cnt_n;
      appleLocX <= loc_x_n;
      appleLocY <= loc_y_n;
    end
  end

endmodule
